axi4_uart_tx_slave: RTL and testbench

AXI4 slave UART transmitter with a parametrised byte FIFO, a runtime-programmable baud divisor and a readable status register. It sits on the eclass data master port at the UART window. It decouples CPU stores from the serial line through write backpressure when the FIFO is full. It replaces free-running, address-snooped UART triggering with a real AW/W/B and AR/R handshake.

---
 rtl/axi4_uart_tx_slave.sv | 318 +++++++++++++++++++++++++++++++
 tb/tb_axi4_uart_tx_slave.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_uart_tx_slave.sv
// AXI4 slave UART transmitter: TXDATA/STATUS/CTRL register window in front of a
// byte FIFO and an 8N1 serialiser with a runtime baud divisor latched per frame.
module axi4_uart_tx_slave #(
  parameter int FIFO_DEPTH    = 16,
  parameter int ID_W          = 4,
  parameter int BAUD_DIV_INIT = 1250
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            s_AWVALID,
  output logic            s_AWREADY,
  input  logic [31:0]     s_AWADDR,
  input  logic [7:0]      s_AWLEN,
  input  logic [ID_W-1:0] s_AWID,
  input  logic            s_WVALID,
  output logic            s_WREADY,
  input  logic [31:0]     s_WDATA,
  input  logic [3:0]      s_WSTRB,
  input  logic            s_WLAST,
  output logic            s_BVALID,
  input  logic            s_BREADY,
  output logic [1:0]      s_BRESP,
  output logic [ID_W-1:0] s_BID,
  input  logic            s_ARVALID,
  output logic            s_ARREADY,
  input  logic [31:0]     s_ARADDR,
  input  logic [7:0]      s_ARLEN,
  input  logic [ID_W-1:0] s_ARID,
  output logic            s_RVALID,
  input  logic            s_RREADY,
  output logic [31:0]     s_RDATA,
  output logic [1:0]      s_RRESP,
  output logic            s_RLAST,
  output logic [ID_W-1:0] s_RID,
  output logic            uart_tx,
  output logic            irq_tx_empty
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] A_TXDATA = 2'd0;
  localparam logic [1:0] A_STATUS = 2'd1;
  localparam logic [1:0] A_CTRL   = 2'd2;
  localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   LVL_FULL = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  typedef enum logic [1:0] {W_ADDR, W_DATA, W_RESP} wstate_e;
  typedef enum logic       {R_ADDR, R_DATA} rstate_e;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} txstate_e;

  // ---------------- write channel FSM ----------------
  wstate_e         wstate_q;
  logic            awready_q, bvalid_q;
  logic [1:0]      bresp_q, waddr_q;
  logic [ID_W-1:0] bid_q;
  logic            fifo_full, fifo_empty;
  logic            w_beat;

  assign s_WREADY  = (wstate_q == W_DATA) && !((waddr_q == A_TXDATA) && fifo_full);
  assign w_beat    = s_WVALID && s_WREADY;
  assign s_AWREADY = awready_q;
  assign s_BVALID  = bvalid_q;
  assign s_BRESP   = bresp_q;
  assign s_BID     = bid_q;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      wstate_q  <= W_ADDR;
      awready_q <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      bid_q     <= '0;
      waddr_q   <= '0;
    end else begin
      case (wstate_q)
        W_ADDR: begin
          if (awready_q && s_AWVALID) begin
            waddr_q   <= s_AWADDR[3:2];
            bid_q     <= s_AWID;
            awready_q <= 1'b0;
            wstate_q  <= W_DATA;
          end else begin
            awready_q <= 1'b1;
          end
        end
        W_DATA: begin
          if (w_beat && s_WLAST) begin
            wstate_q <= W_RESP;
            bvalid_q <= 1'b1;
            bresp_q  <= (waddr_q == 2'd3) ? RESP_SLVERR : RESP_OKAY;
          end
        end
        W_RESP: begin
          if (s_BREADY) begin
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            wstate_q  <= W_ADDR;
          end
        end
        default: wstate_q <= W_ADDR;
      endcase
    end
  end

  // ---------------- CTRL register ----------------
  logic [15:0] baud_div_q, baud_div_d, div_new;
  logic        irq_en_q, irq_en_d;
  logic        ctrl_wr;

  assign ctrl_wr = w_beat && (waddr_q == A_CTRL);

  always_comb begin
    div_new = baud_div_q;
    if (s_WSTRB[0]) div_new[7:0]  = s_WDATA[7:0];
    if (s_WSTRB[1]) div_new[15:8] = s_WDATA[15:8];
    baud_div_d = baud_div_q;
    irq_en_d   = irq_en_q;
    if (ctrl_wr) begin
      baud_div_d = (div_new < 16'd2) ? 16'd2 : div_new;
      if (s_WSTRB[2]) irq_en_d = s_WDATA[16];
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      baud_div_q <= 16'(BAUD_DIV_INIT);
      irq_en_q   <= 1'b0;
    end else begin
      baud_div_q <= baud_div_d;
      irq_en_q   <= irq_en_d;
    end
  end

  // ---------------- TX FIFO ----------------
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic          push, pop;

  assign push       = w_beat && (waddr_q == A_TXDATA) && s_WSTRB[0];
  assign fifo_full  = (level_q == LVL_FULL);
  assign fifo_empty = (level_q == '0);

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    level_d  = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (push) fifo_mem[wr_ptr_q] <= s_WDATA[7:0];
  end

  // ---------------- serialiser ----------------
  txstate_e    tx_state_q;
  logic        tx_q, irq_q;
  logic [7:0]  shreg_q;
  logic [2:0]  bit_cnt_q;
  logic [15:0] baud_cnt_q, div_lat_q;
  logic        bit_done;

  assign bit_done = (baud_cnt_q == div_lat_q - 16'd1);
  // Back-to-back frames: the next byte is taken on the stop bit's last cycle.
  assign pop = !fifo_empty &&
               ((tx_state_q == TX_IDLE) || ((tx_state_q == TX_STOP) && bit_done));

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      tx_state_q <= TX_IDLE;
      tx_q       <= 1'b1;
      shreg_q    <= '0;
      bit_cnt_q  <= '0;
      baud_cnt_q <= '0;
      div_lat_q  <= 16'(BAUD_DIV_INIT);
    end else if (pop) begin
      tx_state_q <= TX_START;
      tx_q       <= 1'b0;
      shreg_q    <= fifo_mem[rd_ptr_q];
      baud_cnt_q <= '0;
      div_lat_q  <= baud_div_q;
    end else begin
      case (tx_state_q)
        TX_IDLE: tx_q <= 1'b1;
        TX_START: begin
          if (bit_done) begin
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            tx_q       <= shreg_q[0];
            tx_state_q <= TX_DATA;
          end else begin
            baud_cnt_q <= baud_cnt_q + 16'd1;
          end
        end
        TX_DATA: begin
          if (bit_done) begin
            baud_cnt_q <= '0;
            if (bit_cnt_q == 3'd7) begin
              tx_q       <= 1'b1;
              tx_state_q <= TX_STOP;
            end else begin
              bit_cnt_q <= bit_cnt_q + 3'd1;
              shreg_q   <= shreg_q >> 1;
              tx_q      <= shreg_q[1];
            end
          end else begin
            baud_cnt_q <= baud_cnt_q + 16'd1;
          end
        end
        TX_STOP: begin
          if (bit_done) begin
            baud_cnt_q <= '0;
            tx_q       <= 1'b1;
            tx_state_q <= TX_IDLE;
          end else begin
            baud_cnt_q <= baud_cnt_q + 16'd1;
          end
        end
        default: tx_state_q <= TX_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) irq_q <= 1'b0;
    else        irq_q <= irq_en_q && fifo_empty && (tx_state_q == TX_IDLE);
  end

  assign uart_tx      = tx_q;
  assign irq_tx_empty = irq_q;

  // ---------------- read channel FSM ----------------
  rstate_e         rstate_q;
  logic            arready_q, rvalid_q;
  logic [1:0]      raddr_q;
  logic [7:0]      rcnt_q;
  logic [ID_W-1:0] rid_q;
  logic [31:0]     reg_rdata;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      rstate_q  <= R_ADDR;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      raddr_q   <= '0;
      rcnt_q    <= '0;
      rid_q     <= '0;
    end else begin
      case (rstate_q)
        R_ADDR: begin
          if (arready_q && s_ARVALID) begin
            raddr_q   <= s_ARADDR[3:2];
            rid_q     <= s_ARID;
            rcnt_q    <= s_ARLEN;
            rvalid_q  <= 1'b1;
            arready_q <= 1'b0;
            rstate_q  <= R_DATA;
          end else begin
            arready_q <= 1'b1;
          end
        end
        R_DATA: begin
          if (s_RREADY) begin
            if (rcnt_q == 8'd0) begin
              rvalid_q  <= 1'b0;
              arready_q <= 1'b1;
              rstate_q  <= R_ADDR;
            end else begin
              rcnt_q <= rcnt_q - 8'd1;
            end
          end
        end
        default: rstate_q <= R_ADDR;
      endcase
    end
  end

  // Register contents are muxed live so every beat sees current state.
  always_comb begin
    reg_rdata = '0;
    case (raddr_q)
      A_STATUS: reg_rdata = {16'h0, 8'(level_q), 5'b0,
                             tx_state_q != TX_IDLE, fifo_empty, fifo_full};
      A_CTRL:   reg_rdata = {15'h0, irq_en_q, baud_div_q};
      default:  reg_rdata = '0;
    endcase
  end

  assign s_ARREADY = arready_q;
  assign s_RVALID  = rvalid_q;
  assign s_RDATA   = rvalid_q ? reg_rdata : 32'h0;
  assign s_RRESP   = (rvalid_q && raddr_q == 2'd3) ? RESP_SLVERR : RESP_OKAY;
  assign s_RLAST   = rvalid_q && (rcnt_q == 8'd0);
  assign s_RID     = rid_q;

  logic unused_ok;
  assign unused_ok = ^{s_AWADDR[31:4], s_AWADDR[1:0], s_ARADDR[31:4], s_ARADDR[1:0],
                       s_AWLEN, s_WDATA[31:17], s_WSTRB[3]};

endmodule

// File: tb/tb_axi4_uart_tx_slave.sv
// Directed bench for axi4_uart_tx_slave: register vector table plus serial-line
// sequences checked against a per-cycle log of uart_tx.
module tb_axi4_uart_tx_slave;
  logic        CLK = 1'b0;
  logic        RST_N;
  logic        s_AWVALID, s_AWREADY, s_WVALID, s_WREADY, s_WLAST;
  logic [31:0] s_AWADDR, s_WDATA, s_ARADDR, s_RDATA;
  logic [7:0]  s_AWLEN, s_ARLEN;
  logic [3:0]  s_AWID, s_ARID, s_BID, s_RID, s_WSTRB;
  logic        s_BVALID, s_BREADY, s_ARVALID, s_ARREADY, s_RVALID, s_RREADY, s_RLAST;
  logic [1:0]  s_BRESP, s_RRESP;
  logic        uart_tx, irq_tx_empty;

  axi4_uart_tx_slave #(.FIFO_DEPTH(16), .ID_W(4), .BAUD_DIV_INIT(1250)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .s_AWVALID(s_AWVALID), .s_AWREADY(s_AWREADY), .s_AWADDR(s_AWADDR),
    .s_AWLEN(s_AWLEN), .s_AWID(s_AWID),
    .s_WVALID(s_WVALID), .s_WREADY(s_WREADY), .s_WDATA(s_WDATA),
    .s_WSTRB(s_WSTRB), .s_WLAST(s_WLAST),
    .s_BVALID(s_BVALID), .s_BREADY(s_BREADY), .s_BRESP(s_BRESP), .s_BID(s_BID),
    .s_ARVALID(s_ARVALID), .s_ARREADY(s_ARREADY), .s_ARADDR(s_ARADDR),
    .s_ARLEN(s_ARLEN), .s_ARID(s_ARID),
    .s_RVALID(s_RVALID), .s_RREADY(s_RREADY), .s_RDATA(s_RDATA),
    .s_RRESP(s_RRESP), .s_RLAST(s_RLAST), .s_RID(s_RID),
    .uart_tx(uart_tx), .irq_tx_empty(irq_tx_empty)
  );

  always #5 CLK = ~CLK;

  int   cyc = 0;
  logic line_log [0:8191];
  always @(posedge CLK) cyc <= cyc + 1;
  always @(negedge CLK) if (cyc < 8192) line_log[cyc] <= uart_tx;

  int checks = 0;
  int failures = 0;
  logic [31:0] rd_data [4];
  logic [1:0]  rd_resp [4];
  logic        rd_last [4];

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  exp_resp;
    logic [31:0] exp_rdata;
    logic        exp_irq;
  } vec_t;
  vec_t vt [14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  // Waits (bounded) until sig is high; returns 0 on timeout and records a failure.
  task automatic wait_hi(input string nm, input int which, output bit ok);
    int n = 0;
    logic s;
    ok = 1'b1;
    forever begin
      case (which)
        0: s = s_AWREADY; 1: s = s_WREADY; 2: s = s_BVALID;
        3: s = s_ARREADY; 4: s = s_RVALID; default: s = ~uart_tx;
      endcase
      if (s === 1'b1) break;
      if (n >= 300) begin
        checks++; failures++; ok = 1'b0;
        $display("FAIL timeout_%s actual=no_event required=event", nm);
        break;
      end
      tick(); n++;
    end
  endtask

  task automatic axi_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                        input bit get_b, output logic [1:0] resp, output int w_edge,
                        output logic b_next);
    bit ok;
    resp = 2'bxx; w_edge = 0; b_next = 1'b0;
    s_AWVALID = 1; s_AWADDR = a; s_AWLEN = 0; s_AWID = 4'h5;
    wait_hi("aw", 0, ok);
    tick(); s_AWVALID = 0;
    s_WVALID = 1; s_WDATA = d; s_WSTRB = s; s_WLAST = 1;
    wait_hi("w", 1, ok);
    tick(); s_WVALID = 0; s_WLAST = 0;
    w_edge = cyc; b_next = s_BVALID;
    if (get_b) begin
      s_BREADY = 1;
      wait_hi("b", 2, ok);
      resp = s_BRESP;
      tick(); s_BREADY = 0;
    end
  endtask

  task automatic axi_rd(input logic [31:0] a, input logic [7:0] len, output logic first_now);
    bit ok;
    s_ARVALID = 1; s_ARADDR = a; s_ARLEN = len; s_ARID = 4'h9;
    wait_hi("ar", 3, ok);
    tick(); s_ARVALID = 0;
    first_now = s_RVALID;
    s_RREADY = 1;
    for (int b = 0; b <= int'(len) && b < 4; b++) begin
      wait_hi("r", 4, ok);
      rd_data[b] = s_RDATA; rd_resp[b] = s_RRESP; rd_last[b] = s_RLAST;
      tick();
    end
    s_RREADY = 0;
  endtask

  task automatic axi_burst(input logic [31:0] a, input int n, input logic [7:0] base,
                           output int e0, output bit stalled, output int nb);
    bit ok;
    e0 = 0; stalled = 0; nb = 0;
    s_AWVALID = 1; s_AWADDR = a; s_AWLEN = 8'(n - 1); s_AWID = 4'h3;
    wait_hi("baw", 0, ok);
    tick(); s_AWVALID = 0;
    for (int i = 0; i < n; i++) begin
      s_WVALID = 1; s_WDATA = {24'h0, base + 8'(i)}; s_WSTRB = 4'hF; s_WLAST = (i == n - 1);
      if (s_WREADY !== 1'b1 && i > 0) stalled = 1;
      wait_hi("bw", 1, ok);
      tick();
      if (i == 0) e0 = cyc;
    end
    s_WVALID = 0; s_WLAST = 0;
    s_BREADY = 1;
    for (int k = 0; k < 10; k++) begin
      if (s_BVALID === 1'b1) nb++;
      tick();
    end
    s_BREADY = 0;
  endtask

  function automatic int frame_err(input int s, input logic [7:0] b, input int div);
    int err = 0;
    logic e;
    for (int bt = 0; bt < 10; bt++) begin
      e = (bt == 0) ? 1'b0 : (bt == 9) ? 1'b1 : b[bt-1];
      for (int c = 0; c < div; c++) begin
        if (s + bt * div + c >= 8192 || line_log[s + bt * div + c] !== e) err++;
      end
    end
    return err;
  endfunction

  initial begin
    logic [1:0] resp;
    int   we, e0, nb, errs, e1, w2;
    logic bn, fn;
    bit   stalled, ok;

    vt[0]  = '{0, 32'h4, 0, 0,        2'b00, 32'h0000_0002, 0};
    vt[1]  = '{0, 32'h8, 0, 0,        2'b00, 32'h0000_04E2, 0};
    vt[2]  = '{1, 32'h8, 32'h1, 4'hF, 2'b00, 0, 0};
    vt[3]  = '{0, 32'h8, 0, 0,        2'b00, 32'h0000_0002, 0};
    vt[4]  = '{1, 32'h8, 32'h0001_0007, 4'hF, 2'b00, 0, 1};
    vt[5]  = '{0, 32'h8, 0, 0,        2'b00, 32'h0001_0007, 1};
    vt[6]  = '{1, 32'h8, 32'h3, 4'h1, 2'b00, 0, 1};
    vt[7]  = '{0, 32'h8, 0, 0,        2'b00, 32'h0001_0003, 1};
    vt[8]  = '{0, 32'h0, 0, 0,        2'b00, 32'h0, 1};
    vt[9]  = '{0, 32'hC, 0, 0,        2'b10, 32'h0, 1};
    vt[10] = '{1, 32'hC, 32'hFF, 4'hF, 2'b10, 0, 1};
    vt[11] = '{0, 32'h4, 0, 0,        2'b00, 32'h0000_0002, 1};
    vt[12] = '{1, 32'h8, 32'h2, 4'hF, 2'b00, 0, 0};
    vt[13] = '{0, 32'h8, 0, 0,        2'b00, 32'h0000_0002, 0};

    RST_N = 0;
    s_AWVALID = 0; s_AWADDR = 0; s_AWLEN = 0; s_AWID = 0;
    s_WVALID = 0; s_WDATA = 0; s_WSTRB = 0; s_WLAST = 0; s_BREADY = 0;
    s_ARVALID = 0; s_ARADDR = 0; s_ARLEN = 0; s_ARID = 0; s_RREADY = 0;
    repeat (3) tick();

    chk("rst_uart_tx", 32'(uart_tx), 1);
    chk("rst_awready", 32'(s_AWREADY), 0);
    chk("rst_arready", 32'(s_ARREADY), 0);
    chk("rst_bvalid", 32'(s_BVALID), 0);
    chk("rst_rvalid", 32'(s_RVALID), 0);
    chk("rst_irq", 32'(irq_tx_empty), 0);
    RST_N = 1;
    tick();
    chk("awready_after_rst", 32'(s_AWREADY), 1);
    chk("arready_after_rst", 32'(s_ARREADY), 1);

    for (int i = 0; i < 14; i++) begin
      if (vt[i].wr) begin
        axi_wr(vt[i].addr, vt[i].data, vt[i].strb, 1, resp, we, bn);
        chk($sformatf("vec%0d_bresp", i), 32'(resp), 32'(vt[i].exp_resp));
      end else begin
        axi_rd(vt[i].addr, 0, fn);
        chk($sformatf("vec%0d_rdata", i), rd_data[0], vt[i].exp_rdata);
        chk($sformatf("vec%0d_rresp", i), 32'(rd_resp[0]), 32'(vt[i].exp_resp));
        chk($sformatf("vec%0d_rlast", i), 32'(rd_last[0]), 1);
      end
      repeat (2) tick();
      chk($sformatf("vec%0d_irq", i), 32'(irq_tx_empty), 32'(vt[i].exp_irq));
    end

    // single byte 0x55 at div 2
    axi_wr(32'h0, 32'h55, 4'h1, 1, resp, we, bn);
    chk("tx55_bresp", 32'(resp), 0);
    chk("tx55_bvalid_next", 32'(bn), 1);
    repeat (30) tick();
    chk("tx55_idle_before_start", 32'(line_log[we]), 1);
    chk("tx55_frame", 32'(frame_err(we + 1, 8'h55, 2)), 0);

    // 18-beat burst into a 16-deep FIFO
    axi_burst(32'h0, 18, 8'h20, e0, stalled, nb);
    chk("burst_stall_seen", 32'(stalled), 1);
    chk("burst_one_b", 32'(nb), 1);
    repeat (380) tick();
    errs = 0;
    for (int k = 0; k < 18; k++) errs += frame_err(e0 + 1 + 20 * k, 8'h20 + 8'(k), 2);
    chk("burst_frames", 32'(errs), 0);
    chk("burst_idle_after", 32'(line_log[e0 + 1 + 360]), 1);

    // reserved offset
    axi_wr(32'hC, 32'h1234, 4'hF, 1, resp, we, bn);
    chk("rsvd_bresp", 32'(resp), 2);
    axi_rd(32'hC, 1, fn);
    chk("rsvd_rvalid_next", 32'(fn), 1);
    chk("rsvd_b0_data", rd_data[0], 0);
    chk("rsvd_b0_resp", 32'(rd_resp[0]), 2);
    chk("rsvd_b0_last", 32'(rd_last[0]), 0);
    chk("rsvd_b1_data", rd_data[1], 0);
    chk("rsvd_b1_resp", 32'(rd_resp[1]), 2);
    chk("rsvd_b1_last", 32'(rd_last[1]), 1);

    // divisor change mid-frame
    axi_wr(32'h8, 32'h4, 4'hF, 1, resp, we, bn);
    axi_wr(32'h0, 32'hA3, 4'h1, 1, resp, e1, bn);
    axi_wr(32'h0, 32'h3C, 4'h1, 1, resp, w2, bn);
    axi_wr(32'h8, 32'h8, 4'hF, 1, resp, we, bn);
    chk("divchg_before_frame_end", 32'(we < e1 + 40), 1);
    repeat (140) tick();
    chk("divchg_frame1_div4", 32'(frame_err(e1 + 1, 8'hA3, 4)), 0);
    chk("divchg_frame2_div8", 32'(frame_err(e1 + 41, 8'h3C, 8)), 0);
    chk("divchg_idle_after", 32'(line_log[e1 + 121]), 1);

    // reset mid-frame with 5 bytes queued and a B response outstanding
    axi_burst(32'h0, 6, 8'h10, e0, stalled, nb);
    axi_rd(32'h4, 0, fn);
    chk("pre_rst_status", rd_data[0], 32'h0000_0504);
    axi_wr(32'hC, 32'h0, 4'hF, 0, resp, we, bn);
    chk("pre_rst_bvalid", 32'(s_BVALID), 1);
    wait_hi("line_low", 5, ok);
    RST_N = 0;
    tick();
    chk("midrst_uart_tx", 32'(uart_tx), 1);
    chk("midrst_bvalid", 32'(s_BVALID), 0);
    RST_N = 1;
    tick();
    axi_rd(32'h4, 0, fn);
    chk("midrst_status", rd_data[0], 32'h0000_0002);
    axi_rd(32'h8, 0, fn);
    chk("midrst_ctrl", rd_data[0], 32'h0000_04E2);
    chk("midrst_line_idle", 32'(uart_tx), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
